approx_err_monitor: RTL

APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

---
 rtl/approx_err_monitor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for an approximate adder: compares each sample against the
// exact sum and accumulates count, error count, max error distance and sum of squared errors.
module approx_err_monitor #(
    parameter int W  = 16,
    parameter int CW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_a,
    input  logic [W-1:0]          in_b,
    input  logic [W:0]            in_approx,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CW-1:0]         res_count,
    output logic [CW-1:0]         res_err_count,
    output logic [W:0]            res_max_ed,
    output logic [2*W+2+CW-1:0]   res_sse,
    output logic                  busy
);

    localparam int QW = 2 * W + 2;
    localparam int SW = QW + CW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_drain_cnt;

    logic          w_accept;
    logic          w_start_ok;
    logic [W:0]    w_exact;
    logic [W:0]    w_ed;
    logic          r_s1_valid;
    logic [W:0]    r_s1_ed;

    logic [QW-1:0] w_ed_ext;
    logic [QW-1:0] w_sq;
    logic [SW:0]   w_sse_sum;

    logic [CW-1:0] r_count;
    logic [CW-1:0] r_err_count;
    logic [W:0]    r_max_ed;
    logic [SW-1:0] r_sse;

    // NOTE: state registers use <= so every flop samples pre-edge values; comb logic uses = with defaults first so no latches form.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)       w_next_state = S_RUN;
            S_RUN:   if (stop)        w_next_state = S_DRAIN;
            S_DRAIN: if (r_drain_cnt) w_next_state = S_DONE;
            S_DONE:  if (res_ready)   w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    assign in_ready   = (r_state == S_RUN);
    assign busy       = (r_state != S_IDLE);
    assign res_valid  = (r_state == S_DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_start_ok = start && (r_state == S_IDLE);

    // Stage 1: exact sum and unsigned error distance.
    assign w_exact = {1'b0, in_a} + {1'b0, in_b};
    assign w_ed    = (w_exact >= in_approx) ? (w_exact - in_approx) : (in_approx - w_exact);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ed    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_ed <= w_ed;
            end
        end
    end

    // Stage 2: the square fits exactly in QW bits; the extra sum bit detects sse overflow.
    assign w_ed_ext  = {{(W + 1){1'b0}}, r_s1_ed};
    assign w_sq      = w_ed_ext * w_ed_ext;
    assign w_sse_sum = {1'b0, r_sse} + {{(CW + 1){1'b0}}, w_sq};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_err_count <= '0;
            r_max_ed    <= '0;
            r_sse       <= '0;
        end else if (w_start_ok) begin
            r_count     <= '0;
            r_err_count <= '0;
            r_max_ed    <= '0;
            r_sse       <= '0;
        end else if (r_s1_valid) begin
            if (!(&r_count)) begin
                r_count <= r_count + 1'b1;
            end
            if ((|r_s1_ed) && !(&r_err_count)) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (r_s1_ed > r_max_ed) begin
                r_max_ed <= r_s1_ed;
            end
            r_sse <= w_sse_sum[SW] ? {SW{1'b1}} : w_sse_sum[SW-1:0];
        end
    end

    assign res_count     = r_count;
    assign res_err_count = r_err_count;
    assign res_max_ed    = r_max_ed;
    assign res_sse       = r_sse;

endmodule
